// File: rtl/mic_pkt_fifo.sv
// -----------------------------------------------------------------------------
// mic_pkt_fifo
//   Store-and-forward packet FIFO for one MIC stream link (64-bit data + TLAST).
//   A packet is only presented downstream once its TLAST beat is stored, so a
//   completer never sees a partially arrived packet. If a single packet is
//   longer than the FIFO (FIFO full, no complete packet held), the FIFO falls
//   back to cut-through until that packet's TLAST beat leaves, which avoids a
//   deadlock.
//
// Parameters
//   DEPTH_LOG2   log2 of FIFO depth in beats (legal 2..10)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   I_TVALID/I_TREADY/I_TDATA/I_TLAST   input stream
//   O_TVALID/O_TREADY/O_TDATA/O_TLAST   output stream
//   level        beats currently stored
//   pkts         complete packets currently stored
//
// Optional statistics (compile with MIC_PKT_FIFO_STATS_EN defined):
//   stat_pkts_out   packets sent, wrapping 32-bit counter
//   stat_max_level  high-water mark of level
//   stat_ct_events  store-and-forward -> cut-through transitions, saturating
// -----------------------------------------------------------------------------
module mic_pkt_fifo #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  I_TVALID,
    output logic                  I_TREADY,
    input  logic [63:0]           I_TDATA,
    input  logic                  I_TLAST,
    output logic                  O_TVALID,
    input  logic                  O_TREADY,
    output logic [63:0]           O_TDATA,
    output logic                  O_TLAST,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   pkts
`ifdef MIC_PKT_FIFO_STATS_EN
    ,
    output logic [31:0]           stat_pkts_out,
    output logic [DEPTH_LOG2:0]   stat_max_level,
    output logic [15:0]           stat_ct_events
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};

    typedef enum logic {
        MODE_SF = 1'b0,
        MODE_CT = 1'b1
    } mode_t;

    logic [64:0]         mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic [DEPTH_LOG2:0] pkts_r;
    logic [DEPTH_LOG2:0] level_r;
    logic [DEPTH_LOG2:0] pkts_nxt_s;
    logic [DEPTH_LOG2:0] level_nxt_s;
    logic                rst_done_r;
    mode_t               mode_r;
    mode_t               mode_nxt_s;
    logic                empty_s;
    logic                full_s;
    logic                wr_en_s;
    logic                rd_en_s;
    logic                o_valid_s;
    logic                pkt_in_s;
    logic                pkt_out_s;
    logic [64:0]         rd_word_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                     (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);

    // rst_done_r keeps I_TREADY low while reset is held and for the release
    // cycle, independent of the (cleared) pointers.
    assign I_TREADY  = rst_done_r & ~full_s;
    assign wr_en_s   = I_TVALID & I_TREADY;
    assign rd_en_s   = o_valid_s & O_TREADY;
    assign rd_word_s = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    assign pkt_in_s  = wr_en_s & I_TLAST;
    assign pkt_out_s = rd_en_s & rd_word_s[64];

    assign O_TVALID = o_valid_s;
    assign O_TDATA  = rd_word_s[63:0];
    // The storage array is not reset, so TLAST is qualified with valid.
    assign O_TLAST  = rd_word_s[64] & o_valid_s;
    assign level    = level_r;
    assign pkts     = pkts_r;

    // Storage array write port (no reset: contents are qualified by pointers).
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= {I_TLAST, I_TDATA};
        end
    end

    // Reset-release flag gating input acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= CNT_ZERO;
            rd_ptr_r <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + CNT_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + CNT_ONE;
            end
        end
    end

    // Next values for packet count and beat level.
    always_comb begin
        pkts_nxt_s  = pkts_r;
        level_nxt_s = level_r;
        case ({pkt_in_s, pkt_out_s})
            2'b10:   pkts_nxt_s = pkts_r + CNT_ONE;
            2'b01:   pkts_nxt_s = pkts_r - CNT_ONE;
            default: pkts_nxt_s = pkts_r;
        endcase
        case ({wr_en_s, rd_en_s})
            2'b10:   level_nxt_s = level_r + CNT_ONE;
            2'b01:   level_nxt_s = level_r - CNT_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Packet count and beat level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkts_r  <= CNT_ZERO;
            level_r <= CNT_ZERO;
        end else begin
            pkts_r  <= pkts_nxt_s;
            level_r <= level_nxt_s;
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r <= MODE_SF;
        end else begin
            mode_r <= mode_nxt_s;
        end
    end

    // Mode next-state and output-valid decode. The CT exit term is written
    // from registered state and O_TREADY directly (not via rd_en_s) so this
    // block does not read back its own output.
    always_comb begin
        mode_nxt_s = mode_r;
        o_valid_s  = 1'b0;
        case (mode_r)
            MODE_SF: begin
                o_valid_s = ~empty_s & (pkts_r != CNT_ZERO);
                // Full with no complete packet: one packet is longer than
                // the FIFO and would never complete without cut-through.
                if (full_s && (pkts_r == CNT_ZERO)) begin
                    mode_nxt_s = MODE_CT;
                end else begin
                    mode_nxt_s = MODE_SF;
                end
            end
            MODE_CT: begin
                o_valid_s = ~empty_s;
                if (~empty_s && O_TREADY && rd_word_s[64]) begin
                    mode_nxt_s = MODE_SF;
                end else begin
                    mode_nxt_s = MODE_CT;
                end
            end
            default: begin
                o_valid_s  = 1'b0;
                mode_nxt_s = MODE_SF;
            end
        endcase
    end

`ifdef MIC_PKT_FIFO_STATS_EN
    logic [31:0]         stat_pkts_out_r;
    logic [DEPTH_LOG2:0] stat_max_level_r;
    logic [15:0]         stat_ct_events_r;

    assign stat_pkts_out  = stat_pkts_out_r;
    assign stat_max_level = stat_max_level_r;
    assign stat_ct_events = stat_ct_events_r;

    // Statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pkts_out_r  <= 32'd0;
            stat_max_level_r <= CNT_ZERO;
            stat_ct_events_r <= 16'd0;
        end else begin
            if (pkt_out_s) begin
                stat_pkts_out_r <= stat_pkts_out_r + 32'd1;
            end
            if (level_nxt_s > stat_max_level_r) begin
                stat_max_level_r <= level_nxt_s;
            end
            if ((mode_r == MODE_SF) && (mode_nxt_s == MODE_CT) &&
                (stat_ct_events_r != 16'hffff)) begin
                stat_ct_events_r <= stat_ct_events_r + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mic_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_mic_pkt_fifo
//   Directed and randomized checks for mic_pkt_fifo with a 4-beat FIFO.
//   Inputs are driven 1 time unit after the rising edge, outputs are sampled
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_mic_pkt_fifo;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic            clk;
    logic            reset;
    logic            I_TVALID;
    logic            I_TREADY;
    logic [63:0]     I_TDATA;
    logic            I_TLAST;
    logic            O_TVALID;
    logic            O_TREADY;
    logic [63:0]     O_TDATA;
    logic            O_TLAST;
    logic [DL2:0]    level;
    logic [DL2:0]    pkts;
`ifdef MIC_PKT_FIFO_STATS_EN
    logic [31:0]     stat_pkts_out;
    logic [DL2:0]    stat_max_level;
    logic [15:0]     stat_ct_events;
`endif

    int n_cmp;
    int n_err;

    // Reference state for the traffic runner.
    logic [64:0] in_q [$];
    logic [64:0] sb_q [$];
    int          m_lvl;
    int          m_pkts;
    bit          m_ct;
    bit          saw_ct;

    mic_pkt_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .reset    (reset),
        .I_TVALID (I_TVALID),
        .I_TREADY (I_TREADY),
        .I_TDATA  (I_TDATA),
        .I_TLAST  (I_TLAST),
        .O_TVALID (O_TVALID),
        .O_TREADY (O_TREADY),
        .O_TDATA  (O_TDATA),
        .O_TLAST  (O_TLAST),
        .level    (level),
        .pkts     (pkts)
`ifdef MIC_PKT_FIFO_STATS_EN
        ,
        .stat_pkts_out  (stat_pkts_out),
        .stat_max_level (stat_max_level),
        .stat_ct_events (stat_ct_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams in_q through the DUT with the given valid/ready percentages and
    // checks every cycle against a reference model of the FIFO.
    task automatic run_traffic(input int vpct, input int rpct, input int max_cyc, input string tg);
        int          cyc;
        logic        in_acc;
        logic        out_acc;
        logic        exp_last;
        logic [64:0] exp_beat;
        cyc = 0;
        while (((in_q.size() != 0) || (sb_q.size() != 0)) && (cyc < max_cyc)) begin
            if ((in_q.size() != 0) && ($urandom_range(99) < vpct)) begin
                I_TVALID = 1'b1;
                {I_TLAST, I_TDATA} = in_q[0];
            end else begin
                I_TVALID = 1'b0;
            end
            O_TREADY = ($urandom_range(99) < rpct);
            @(negedge clk);
            chk({tg, "_ovalid"}, 64'(O_TVALID), 64'((m_lvl != 0) && (m_ct || (m_pkts != 0))));
            chk({tg, "_iready"}, 64'(I_TREADY), 64'(m_lvl != DEPTH));
            chk({tg, "_level"},  64'(level), 64'(m_lvl));
            chk({tg, "_pkts"},   64'(pkts), 64'(m_pkts));
            in_acc   = I_TVALID & I_TREADY;
            out_acc  = O_TVALID & O_TREADY;
            exp_last = 1'b0;
            if (out_acc) begin
                if (sb_q.size() == 0) begin
                    chk({tg, "_spurious_out"}, 64'd1, 64'd0);
                end else begin
                    exp_beat = sb_q.pop_front();
                    exp_last = exp_beat[64];
                    chk({tg, "_data"}, O_TDATA, exp_beat[63:0]);
                    chk({tg, "_last"}, 64'(O_TLAST), 64'(exp_last));
                end
            end
            if (!m_ct && (m_lvl == DEPTH) && (m_pkts == 0)) begin
                m_ct = 1'b1;
            end else if (m_ct && out_acc && exp_last) begin
                m_ct = 1'b0;
            end
            if (m_ct) begin
                saw_ct = 1'b1;
            end
            if (in_acc) begin
                if (in_q[0][64]) begin
                    m_pkts++;
                end
                sb_q.push_back(in_q.pop_front());
                m_lvl++;
            end
            if (out_acc) begin
                m_lvl--;
                if (exp_last) begin
                    m_pkts--;
                end
            end
            tick();
            cyc++;
        end
        I_TVALID = 1'b0;
        O_TREADY = 1'b0;
        chk({tg, "_done"}, 64'(in_q.size() + sb_q.size()), 64'd0);
    endtask

    initial begin
        int len;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        I_TVALID = 1'b0;
        I_TDATA  = 64'd0;
        I_TLAST  = 1'b0;
        O_TREADY = 1'b0;
        m_lvl    = 0;
        m_pkts   = 0;
        m_ct     = 1'b0;
        saw_ct   = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_iready", 64'(I_TREADY), 64'd0);
        chk("rst_ovalid", 64'(O_TVALID), 64'd0);
        chk("rst_olast",  64'(O_TLAST), 64'd0);
        chk("rst_level",  64'(level), 64'd0);
        chk("rst_pkts",   64'(pkts), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Test 1: reset in the middle of a packet.
        for (int i = 0; i < 3; i++) begin
            I_TVALID = 1'b1;
            I_TDATA  = 64'(i + 1);
            I_TLAST  = 1'b0;
            @(negedge clk);
            chk("t1_iready", 64'(I_TREADY), 64'd1);
            tick();
        end
        I_TVALID = 1'b0;
        chk("t1_level_pre", 64'(level), 64'd3);
        reset = 1'b0;
        #1;
        chk("t1_level", 64'(level), 64'd0);
        chk("t1_pkts", 64'(pkts), 64'd0);
        chk("t1_ovalid", 64'(O_TVALID), 64'd0);
        chk("t1_iready_rst", 64'(I_TREADY), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("t1_iready_release", 64'(I_TREADY), 64'd0);
        tick();
        chk("t1_iready_after", 64'(I_TREADY), 64'd1);

        // Test 2: store-and-forward hold of a 4-beat packet.
        O_TREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            I_TVALID = 1'b1;
            I_TDATA  = 64'h10 + 64'(i);
            I_TLAST  = (i == 3);
            @(negedge clk);
            chk("t2_hold_ovalid", 64'(O_TVALID), 64'd0);
            chk("t2_iready", 64'(I_TREADY), 64'd1);
            tick();
        end
        I_TVALID = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t2_ovalid", 64'(O_TVALID), 64'd1);
            chk("t2_data", O_TDATA, 64'h10 + 64'(j));
            chk("t2_last", 64'(O_TLAST), 64'(j == 3));
            chk("t2_pkts", 64'(pkts), 64'd1);
            tick();
        end
        @(negedge clk);
        chk("t2_end_ovalid", 64'(O_TVALID), 64'd0);
        chk("t2_end_pkts", 64'(pkts), 64'd0);
        chk("t2_end_level", 64'(level), 64'd0);
        O_TREADY = 1'b0;
        tick();

        // Test 3: full FIFO under backpressure, then drain.
        for (int k = 0; k < 4; k++) begin
            I_TVALID = 1'b1;
            I_TDATA  = 64'hA + 64'(k);
            I_TLAST  = 1'b1;
            @(negedge clk);
            chk("t3_fill_iready", 64'(I_TREADY), 64'd1);
            tick();
        end
        I_TDATA = 64'hE;
        @(negedge clk);
        chk("t3_full_iready", 64'(I_TREADY), 64'd0);
        chk("t3_full_level", 64'(level), 64'd4);
        chk("t3_full_pkts", 64'(pkts), 64'd4);
        chk("t3_full_ovalid", 64'(O_TVALID), 64'd1);
        tick();
        O_TREADY = 1'b1;
        @(negedge clk);
        chk("t3_d0_iready", 64'(I_TREADY), 64'd0);
        chk("t3_d0_data", O_TDATA, 64'hA);
        chk("t3_d0_last", 64'(O_TLAST), 64'd1);
        tick();
        @(negedge clk);
        chk("t3_d1_iready", 64'(I_TREADY), 64'd1);
        chk("t3_d1_data", O_TDATA, 64'hB);
        tick();
        I_TVALID = 1'b0;
        @(negedge clk);
        chk("t3_d2_data", O_TDATA, 64'hC);
        chk("t3_d2_level", 64'(level), 64'd3);
        tick();
        @(negedge clk);
        chk("t3_d3_data", O_TDATA, 64'hD);
        tick();
        @(negedge clk);
        chk("t3_d4_data", O_TDATA, 64'hE);
        chk("t3_d4_valid", 64'(O_TVALID), 64'd1);
        tick();
        @(negedge clk);
        chk("t3_end_ovalid", 64'(O_TVALID), 64'd0);
        chk("t3_end_level", 64'(level), 64'd0);
        chk("t3_end_pkts", 64'(pkts), 64'd0);
        O_TREADY = 1'b0;
        tick();

        // Test 5: simultaneous TLAST in and TLAST out.
        I_TVALID = 1'b1;
        I_TDATA  = 64'h50;
        I_TLAST  = 1'b1;
        tick();
        I_TDATA  = 64'h51;
        O_TREADY = 1'b1;
        @(negedge clk);
        chk("t5_ovalid", 64'(O_TVALID), 64'd1);
        chk("t5_data", O_TDATA, 64'h50);
        chk("t5_iready", 64'(I_TREADY), 64'd1);
        chk("t5_pkts_pre", 64'(pkts), 64'd1);
        chk("t5_level_pre", 64'(level), 64'd1);
        tick();
        I_TVALID = 1'b0;
        @(negedge clk);
        chk("t5_pkts_post", 64'(pkts), 64'd1);
        chk("t5_level_post", 64'(level), 64'd1);
        chk("t5_data2", O_TDATA, 64'h51);
        chk("t5_last2", 64'(O_TLAST), 64'd1);
        tick();
        O_TREADY = 1'b0;
        @(negedge clk);
        chk("t5_end_ovalid", 64'(O_TVALID), 64'd0);
        chk("t5_end_pkts", 64'(pkts), 64'd0);
        chk("t5_end_level", 64'(level), 64'd0);
        tick();

        // Test 4: packet longer than the FIFO forces cut-through.
        m_lvl  = 0;
        m_pkts = 0;
        m_ct   = 1'b0;
        saw_ct = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_q.push_back({(i == 5) ? 1'b1 : 1'b0, 64'h40 + 64'(i)});
        end
        run_traffic(100, 100, 100, "t4");
        chk("t4_ct_seen", 64'(saw_ct), 64'd1);
`ifdef MIC_PKT_FIFO_STATS_EN
        chk("t4_stat_ct_events", 64'(stat_ct_events), 64'd1);
`endif
        // A following 3-beat packet must be held again until complete.
        for (int i = 0; i < 3; i++) begin
            in_q.push_back({(i == 2) ? 1'b1 : 1'b0, 64'h60 + 64'(i)});
        end
        run_traffic(100, 100, 100, "t4sf");

        // Test 6: random traffic with 1..9 beat packets.
        for (int p = 0; p < 400; p++) begin
            len = $urandom_range(9, 1);
            for (int b = 0; b < len; b++) begin
                in_q.push_back({(b == len - 1) ? 1'b1 : 1'b0, $urandom, $urandom});
            end
        end
        run_traffic(50, 50, 60000, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
